// File: rtl/pipe_result_checker_if.sv
// Snapshot/golden read bus plus the fetched-instruction tap seen by the result checker.
// The master side is the checker itself; the slave side is the CPU snapshot and golden ROM.
interface pipe_result_checker_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 6
);
  logic [DATA_W-1:0] instr_i;
  logic              instr_valid_i;
  logic              chk_rd_en_o;
  logic              chk_sel_o;
  logic [IDX_W-1:0]  chk_addr_o;
  logic [IDX_W-1:0]  gold_idx_o;
  logic [DATA_W-1:0] act_data_i;
  logic [DATA_W-1:0] gold_data_i;

  modport master (
    input  instr_i, instr_valid_i, act_data_i, gold_data_i,
    output chk_rd_en_o, chk_sel_o, chk_addr_o, gold_idx_o
  );

  modport slave (
    output instr_i, instr_valid_i, act_data_i, gold_data_i,
    input  chk_rd_en_o, chk_sel_o, chk_addr_o, gold_idx_o
  );
endinterface

// File: rtl/pipe_result_checker.sv
// End-of-program checker: waits for a halt fetch, drains the pipeline, then scans data
// memory and register file against a golden image, reporting pass/fail and first error.
module pipe_result_checker #(
  parameter int                DATA_W       = 32,
  parameter int                MEM_DEPTH    = 32,
  parameter int                REG_DEPTH    = 32,
  parameter logic [DATA_W-1:0] HALT_WORD    = {DATA_W{1'b1}},
  parameter int                DRAIN_CYCLES = 4,
  parameter int                TIMEOUT      = 200,
  localparam int               TOTAL        = MEM_DEPTH + REG_DEPTH,
  localparam int               IDX_W        = $clog2(TOTAL),
  localparam int               CNT_W        = $clog2(TOTAL + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pipe_result_checker_if.master bus,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [CNT_W-1:0]      err_cnt_o,
  output logic                  first_err_valid_o,
  output logic [IDX_W-1:0]      first_err_idx_o
);
  localparam int CYC_W = $clog2(TIMEOUT + 1);
  localparam int DRN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TIMEOUT - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TOTAL - 1);
  localparam logic [IDX_W-1:0] MEM_BASE = IDX_W'(MEM_DEPTH);

  typedef enum logic [2:0] {RUN, DRAIN, SCAN, FLUSH, DONE} state_e;

  state_e            state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [DRN_W-1:0]  drn_q, drn_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              cmp_vld_q, cmp_vld_d;
  logic [IDX_W-1:0]  cmp_idx_q, cmp_idx_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic              fev_q, fev_d;
  logic [IDX_W-1:0]  fei_q, fei_d;
  logic              timeout_q, timeout_d;
  logic              halt;

  assign halt = bus.instr_valid_i && (bus.instr_i == HALT_WORD);

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    drn_d     = drn_q;
    idx_d     = idx_q;
    timeout_d = timeout_q;
    err_cnt_d = err_cnt_q;
    fev_d     = fev_q;
    fei_d     = fei_q;
    cmp_vld_d = (state_q == SCAN);
    cmp_idx_d = idx_q;

    case (state_q)
      RUN: begin
        cyc_d = cyc_q + CYC_W'(1);
        // halt beats timeout when both land on the same cycle
        if (halt) begin
          state_d = (DRAIN_CYCLES == 0) ? SCAN : DRAIN;
        end else if (cyc_q == CYC_LAST) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
      end
      DRAIN: begin
        if (drn_q == DRN_LAST) state_d = SCAN;
        else                   drn_d   = drn_q + DRN_W'(1);
      end
      SCAN: begin
        if (idx_q == IDX_LAST) state_d = FLUSH;
        else                   idx_d   = idx_q + IDX_W'(1);
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase

    // read data returns one cycle after the request, so compare against the registered index
    if (cmp_vld_q && (bus.act_data_i != bus.gold_data_i)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
      if (!fev_q) begin
        fev_d = 1'b1;
        fei_d = cmp_idx_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      cyc_q     <= '0;
      drn_q     <= '0;
      idx_q     <= '0;
      cmp_vld_q <= 1'b0;
      cmp_idx_q <= '0;
      err_cnt_q <= '0;
      fev_q     <= 1'b0;
      fei_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      drn_q     <= drn_d;
      idx_q     <= idx_d;
      cmp_vld_q <= cmp_vld_d;
      cmp_idx_q <= cmp_idx_d;
      err_cnt_q <= err_cnt_d;
      fev_q     <= fev_d;
      fei_q     <= fei_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.chk_rd_en_o = (state_q == SCAN);
  assign bus.chk_sel_o   = (idx_q >= MEM_BASE);
  assign bus.chk_addr_o  = bus.chk_sel_o ? (idx_q - MEM_BASE) : idx_q;
  assign bus.gold_idx_o  = idx_q;

  assign done_o            = (state_q == DONE);
  assign pass_o            = done_o && (err_cnt_q == '0) && !timeout_q;
  assign timeout_o         = timeout_q;
  assign err_cnt_o         = err_cnt_q;
  assign first_err_valid_o = fev_q;
  assign first_err_idx_o   = fei_q;
endmodule

// File: tb/tb_pipe_result_checker.sv
// Directed bench for pipe_result_checker: a timeline model predicts every output per cycle,
// and literal expectations pin the key cycle numbers and counts of each scenario.
module tb_pipe_result_checker;
  localparam int TMO = 200;

  logic clk = 1'b0;
  logic rst1 = 1'b1, rst2 = 1'b1;
  always #5 clk = ~clk;

  pipe_result_checker_if #(.DATA_W(32), .IDX_W(6)) if1 ();
  pipe_result_checker_if #(.DATA_W(32), .IDX_W(3)) if2 ();

  logic       d1_done, d1_pass, d1_to, d1_fev;
  logic [6:0] d1_err;
  logic [5:0] d1_fei;
  logic       d2_done, d2_pass, d2_to, d2_fev;
  logic [3:0] d2_err;
  logic [2:0] d2_fei;

  pipe_result_checker u1 (
    .clk_i(clk), .rst_i(rst1), .bus(if1),
    .done_o(d1_done), .pass_o(d1_pass), .timeout_o(d1_to), .err_cnt_o(d1_err),
    .first_err_valid_o(d1_fev), .first_err_idx_o(d1_fei));

  pipe_result_checker #(.MEM_DEPTH(4), .REG_DEPTH(4), .DRAIN_CYCLES(0)) u2 (
    .clk_i(clk), .rst_i(rst2), .bus(if2),
    .done_o(d2_done), .pass_o(d2_pass), .timeout_o(d2_to), .err_cnt_o(d2_err),
    .first_err_valid_o(d2_fev), .first_err_idx_o(d2_fei));

  logic [31:0] gold [64];
  logic [31:0] act  [64];

  int  n_chk = 0, n_fail = 0;
  int  k = 0;
  bit  chk_on = 1'b0, prev_rst = 1'b1, sel_dut = 1'b0;
  int  m_h, m_d, m_total, m_mem;
  int  obs_done, obs_rd_first, obs_rd_cnt, obs_err, obs_fei, obs_fev, obs_pass, obs_to;

  task automatic chk(input string nm, input int a, input int e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s k=%0d actual=%0d expected=%0d", nm, k, a, e);
    end
  endtask

  function automatic int mism_before(input int n);
    int c;
    c = 0;
    for (int j = 0; j < n; j++) if (act[j] !== gold[j]) c++;
    return c;
  endfunction

  function automatic int first_mism(input int n);
    for (int j = 0; j < n; j++) if (act[j] !== gold[j]) return j;
    return 0;
  endfunction

  // snapshot/golden memories: answer each request one cycle later
  initial begin
    int sv1, gv1, sv2, gv2;
    sv1 = 0; gv1 = 0; sv2 = 0; gv2 = 0;
    forever begin
      @(posedge clk); #1;
      if1.act_data_i = act[sv1]; if1.gold_data_i = gold[gv1];
      if2.act_data_i = act[sv2]; if2.gold_data_i = gold[gv2];
      sv1 = if1.chk_sel_o ? 32 + int'(if1.chk_addr_o) : int'(if1.chk_addr_o);
      gv1 = int'(if1.gold_idx_o);
      sv2 = if2.chk_sel_o ? 4 + int'(if2.chk_addr_o) : int'(if2.chk_addr_o);
      gv2 = int'(if2.gold_idx_o);
    end
  end

  // timeline model: outputs follow from halt cycle, drain length, depth and the mismatch set
  always @(negedge clk) begin
    int s, dt, n, e_rd, e_to, e_done, e_err, e_fev, e_fei, e_pass, e_idx, e_sel, e_addr;
    int a_rd, a_done, a_pass, a_to, a_err, a_fev, a_fei, a_idx, a_sel, a_addr;
    if (chk_on) begin
      if (m_h < TMO) begin
        s = m_h + m_d + 1; dt = s + m_total + 1;
        e_rd = (k >= s && k < s + m_total) ? 1 : 0;
        n = k - s - 1;
        if (n < 0) n = 0;
        if (n > m_total) n = m_total;
        e_to = 0;
      end else begin
        s = 0; dt = TMO; e_rd = 0; n = 0;
        e_to = (k >= TMO) ? 1 : 0;
      end
      e_done = (k >= dt) ? 1 : 0;
      e_err  = mism_before(n);
      e_fev  = (e_err > 0) ? 1 : 0;
      e_fei  = e_fev ? first_mism(n) : 0;
      e_pass = (e_done && !e_to && e_err == 0) ? 1 : 0;
      e_idx  = e_rd ? k - s : 0;
      e_sel  = (e_idx >= m_mem) ? 1 : 0;
      e_addr = e_sel ? e_idx - m_mem : e_idx;

      a_rd   = sel_dut ? int'(if2.chk_rd_en_o) : int'(if1.chk_rd_en_o);
      a_done = sel_dut ? int'(d2_done) : int'(d1_done);
      a_pass = sel_dut ? int'(d2_pass) : int'(d1_pass);
      a_to   = sel_dut ? int'(d2_to)   : int'(d1_to);
      a_err  = sel_dut ? int'(d2_err)  : int'(d1_err);
      a_fev  = sel_dut ? int'(d2_fev)  : int'(d1_fev);
      a_fei  = sel_dut ? int'(d2_fei)  : int'(d1_fei);
      a_idx  = sel_dut ? int'(if2.gold_idx_o) : int'(if1.gold_idx_o);
      a_sel  = sel_dut ? int'(if2.chk_sel_o)  : int'(if1.chk_sel_o);
      a_addr = sel_dut ? int'(if2.chk_addr_o) : int'(if1.chk_addr_o);

      chk("rd_en", a_rd, e_rd);
      chk("done", a_done, e_done);
      chk("pass", a_pass, e_pass);
      chk("timeout", a_to, e_to);
      chk("err_cnt", a_err, e_err);
      chk("first_err_valid", a_fev, e_fev);
      chk("first_err_idx", a_fei, e_fei);
      if (e_rd || k == 0) begin
        chk("gold_idx", a_idx, e_idx);
        chk("chk_sel", a_sel, e_sel);
        chk("chk_addr", a_addr, e_addr);
      end

      if (k == 0) begin
        obs_done = -1; obs_rd_first = -1; obs_rd_cnt = 0;
      end
      if (a_done && obs_done < 0) obs_done = k;
      if (a_rd) begin
        if (obs_rd_first < 0) obs_rd_first = k;
        obs_rd_cnt++;
      end
      obs_err = a_err; obs_fei = a_fei; obs_fev = a_fev; obs_pass = a_pass; obs_to = a_to;
    end
  end

  // one clock cycle of stimulus; k tracks cycles since reset release of the selected DUT
  task automatic cyc(input bit rst, input bit hw, input bit hv);
    logic [31:0] w;
    @(posedge clk); #1;
    if (prev_rst) k = 0; else k = k + 1;
    chk_on   = 1'b1;
    prev_rst = rst;
    rst1 = sel_dut ? 1'b1 : rst;
    rst2 = sel_dut ? rst : 1'b1;
    w = $urandom & 32'h7FFF_FFFF;
    if1.instr_i       = hw ? 32'hFFFF_FFFF : w;
    if1.instr_valid_i = hw ? hv : 1'($urandom_range(0, 1));
    if2.instr_i       = if1.instr_i;
    if2.instr_valid_i = if1.instr_valid_i;
  endtask

  task automatic fill(input int f0, input int f1, input int f2);
    for (int i = 0; i < 64; i++) begin
      gold[i] = $urandom;
      act[i]  = gold[i];
    end
    if (f0 >= 0) act[f0] = act[f0] ^ 32'h0000_0010;
    if (f1 >= 0) act[f1] = act[f1] ^ 32'h8000_0000;
    if (f2 >= 0) act[f2] = act[f2] ^ 32'h0001_0001;
  endtask

  // h: valid halt cycle (a second valid halt at h+2 lands in drain/scan and must be ignored)
  // ghost: halt word with valid low; abort: cycle to pulse reset and stop the run
  task automatic scenario(input bit dut, input int h, input int ghost, input int ncyc,
                          input int abort);
    chk_on  = 1'b0;
    sel_dut = dut;
    m_h     = h;
    m_d     = dut ? 0 : 4;
    m_total = dut ? 8 : 64;
    m_mem   = dut ? 4 : 32;
    for (int c = 0; c < ncyc; c++) begin
      if (c == abort) begin
        cyc(1'b1, 1'b0, 1'b0);
        break;
      end
      if (c == h || c == h + 2) cyc(1'b0, 1'b1, 1'b1);
      else if (c == ghost)      cyc(1'b0, 1'b1, 1'b0);
      else                      cyc(1'b0, 1'b0, 1'b0);
    end
    @(negedge clk); #1;
  endtask

  initial begin
    if1.instr_i = '0; if1.instr_valid_i = 1'b0;
    if2.instr_i = '0; if2.instr_valid_i = 1'b0;
    fill(-1, -1, -1);

    // clean run, halt at cycle 10
    scenario(1'b0, 10, -1, 85, -1);
    chk("t1_done_cycle", obs_done, 80);
    chk("t1_rd_pulses", obs_rd_cnt, 64);
    chk("t1_first_rd", obs_rd_first, 15);
    chk("t1_pass", obs_pass, 1);
    chk("t1_err_cnt", obs_err, 0);
    cyc(1'b1, 1'b0, 1'b0);

    // mismatches at memory word 3, register 5 (golden idx 37)
    fill(3, 37, -1);
    scenario(1'b0, 10, -1, 85, -1);
    chk("t2_err_cnt", obs_err, 2);
    chk("t2_first_idx", obs_fei, 3);
    chk("t2_first_valid", obs_fev, 1);
    chk("t2_pass", obs_pass, 0);
    cyc(1'b1, 1'b0, 1'b0);

    // no halt ever
    scenario(1'b0, 1000, -1, 210, -1);
    chk("t3_done_cycle", obs_done, 200);
    chk("t3_timeout", obs_to, 1);
    chk("t3_rd_pulses", obs_rd_cnt, 0);
    chk("t3_pass", obs_pass, 0);
    cyc(1'b1, 1'b0, 1'b0);

    // invalid halt early, valid halt on the timeout cycle
    fill(-1, -1, 63);
    scenario(1'b0, 199, 30, 275, -1);
    chk("t4_timeout", obs_to, 0);
    chk("t4_first_rd", obs_rd_first, 204);
    chk("t4_done_cycle", obs_done, 269);
    chk("t4_first_idx", obs_fei, 63);
    cyc(1'b1, 1'b0, 1'b0);

    // reset while scan is issuing idx 20 with errors already logged, then clean rerun
    fill(3, 5, 50);
    scenario(1'b0, 10, -1, 100, 35);
    chk("t5_err_before_rst", obs_err, 2);
    cyc(1'b1, 1'b0, 1'b0);
    fill(-1, -1, -1);
    scenario(1'b0, 10, -1, 85, -1);
    chk("t5_rerun_pass", obs_pass, 1);
    chk("t5_rerun_done", obs_done, 80);
    cyc(1'b1, 1'b0, 1'b0);

    // small configuration with no drain
    fill(1, 6, -1);
    scenario(1'b1, 10, -1, 30, -1);
    chk("t6_first_rd", obs_rd_first, 11);
    chk("t6_done_cycle", obs_done, 20);
    chk("t6_err_cnt", obs_err, 2);
    chk("t6_first_idx", obs_fei, 1);
    cyc(1'b1, 1'b0, 1'b0);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
